multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle variant of the RV32I core. Sequences the shared datapath (PC, IR, register file, single ALU, immediate generator, unified memory port) through fetch/decode/execute/memory/writeback for R-type, I-type arithmetic, load, store and BEQ/BNE. Handshakes with a variable-latency memory and counts retired instructions. Illegal opcodes or branch funct3 values park it in a sticky trap state.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write request
- addr_sel  out  1  0 = PC, 1 = ALUOut
- ir_we  out  1  latch memory read data into IR
- pc_we  out  1  load PC
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- rf_we  out  1  register file write
- wb_sel  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  2  0 = rs1 (A), 1 = PC, 2 = old PC
- alu_src_b  out  2  0 = rs2 (B), 1 = constant 4, 2 = imm
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = decode from funct fields
- trap  out  1  sticky illegal-instruction flag
- state  out  4  current state encoding (debug)
- instret  out  CNT_W  retired-instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, TRAP=11.
- Outputs not listed for a state are 0.
- IDLE: no outputs asserted. Goes to FETCH next cycle.
- FETCH: mem_req=1, addr_sel=0, alu_src_a=1, alu_src_b=1, alu_op=0. ir_we=pc_we=mem_ready, with pc_src=0 so PC <= PC+4. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=2, alu_src_b=2, alu_op=0, so the branch target (old PC + imm) lands in ALUOut. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 with funct3 000/001 -> BRANCH
  - anything else -> TRAP
- EXEC_R: alu_src_a=0, alu_src_b=0, alu_op=2. Goes to WB_ALU.
- EXEC_I: alu_src_a=0, alu_src_b=2, alu_op=2. Goes to WB_ALU.
- WB_ALU: rf_we=1, wb_sel=0. Retires; goes to FETCH.
- MEM_ADDR: alu_src_a=0, alu_src_b=2, alu_op=0. Goes to MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, addr_sel=1. Waits for mem_ready, then goes to WB_MEM.
- WB_MEM: rf_we=1, wb_sel=1. Retires; goes to FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready, retires and goes to FETCH.
- BRANCH: alu_src_a=0, alu_src_b=0, alu_op=1, pc_src=1.
  - pc_we = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Retires; goes to FETCH.
- TRAP: trap=1, all other control outputs 0. Exit only by reset.
- instret: increments by 1 on each retire event and wraps from all-ones to 0.

## Timing
- Reset (async, immediate): state=IDLE; instret=0; trap=0; all control outputs 0, including mem_req, which drops immediately even mid-handshake.
- Output decoding:
  - Outputs are combinational from the registered state only, except ir_we and pc_we, which also depend on mem_ready (FETCH) or zero/funct3 (BRANCH).
  - opcode and funct3 are sampled only in DECODE, MEM_ADDR and BRANCH.
- Memory handshake:
  - mem_req, mem_we and addr_sel stay stable from first assertion until the cycle mem_ready=1; the transfer completes in that cycle.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Cycle counts with zero wait states:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - each wait cycle adds 1
- First FETCH occurs in the second cycle after rst_n deasserts.

## Test plan
- Reset release, ADDI fetched with mem_ready always 1 -> states 0,1,2,4,8,1; rf_we high exactly in cycle 5; instret=1.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_req=1, addr_sel=1 stable for 4 cycles; WB_MEM follows with wb_sel=1; instret +1.
- BEQ with zero=1, then BNE with zero=1 -> pc_we=1, pc_src=1 in the first BRANCH; pc_we=0 in the second; both retire.
- Opcode 1111111, or branch funct3=100 -> TRAP; trap=1 and mem_req=0 held 20 cycles; instret unchanged.
- rst_n low during FETCH wait -> mem_req=0 in the same cycle; state=0, instret=0.
- instret preloaded near wrap by running 2^CNT_W retires with CNT_W=4 -> count 15 -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle RV32I core.
// Steps the shared datapath through fetch/decode/execute/memory/writeback,
// handshakes with a variable-latency memory port, counts retired
// instructions and parks in a sticky trap state on illegal encodings.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_reg;
  state_t           state_next;
  logic             retire;
  logic [CNT_W-1:0] instret_reg;

  // Next-state selection and retire-event detection
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      IDLE:     state_next = FETCH;
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:               state_next = EXEC_R;
          OP_I:               state_next = EXEC_I;
          OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
          OP_BRANCH:          state_next = (funct3 == 3'b000 || funct3 == 3'b001) ? BRANCH : TRAP;
          default:            state_next = TRAP;
        endcase
      end
      EXEC_R:   state_next = WB_ALU;
      EXEC_I:   state_next = WB_ALU;
      MEM_ADDR: state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_next = WB_MEM;
      MEM_WR: begin
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      WB_ALU, WB_MEM, BRANCH: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      TRAP:     state_next = TRAP;
      default:  state_next = IDLE;
    endcase
  end

  // State register and wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  // Control decode from the registered state; ir_we/pc_we additionally
  // follow mem_ready in FETCH and the branch condition in BRANCH
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    trap      = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
      end
      EXEC_R: alu_op = 2'd2;
      EXEC_I: begin
        alu_src_b = 2'd2;
        alu_op    = 2'd2;
      end
      MEM_ADDR: alu_src_b = 2'd2;
      MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      WB_ALU: rf_we = 1'b1;
      WB_MEM: begin
        rf_we  = 1'b1;
        wb_sel = 1'b1;
      end
      BRANCH: begin
        alu_op = 2'd1;
        pc_src = 1'b1;
        pc_we  = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
      end
      TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: direct vector table, randomized
// instruction stream against a per-instruction step-list model, and
// hand-written reset/trap/wait/wrap sequences.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, wb_sel, trap;
  logic [1:0]    alu_src_a, alu_src_b, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instret;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, wb_sel;
    logic [1:0] a, b, op;
    logic       trap;
  } ctl_t;

  // One expected cycle (or memory phase) of an instruction
  typedef struct {
    logic [3:0] st;
    bit         mem;
    bit         retire;
    bit         sticky;
    ctl_t       c;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         cyc;
    logic [3:0] st3;
    logic       pcwe;
  } vec_t;

  step_t q[$];
  int    model_ret;
  int    n_err = 0;
  int    n_checks = 0;
  bit    rand_ready = 0;
  int    waits_left = 0;
  logic [3:0] wait_state = 4'd6;
  int    n_cyc;
  logic [3:0] st3;
  logic  br_pcwe;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic ctl_t dut_ctl();
    ctl_t g;
    g = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, wb_sel,
         alu_src_a, alu_src_b, alu_op, trap};
    return g;
  endfunction

  task automatic push(input logic [3:0] st, input bit mem, input bit ret, input bit sticky, input ctl_t c);
    step_t s;
    s.st = st; s.mem = mem; s.retire = ret; s.sticky = sticky; s.c = c;
    q.push_back(s);
  endtask

  // Expected step list of one instruction, straight from the per-class rules
  task automatic plan(input logic [6:0] op, input logic [2:0] f3, input logic z);
    ctl_t c;
    c = '0; c.mem_req = 1; c.a = 2'd1; c.b = 2'd1;
    push(4'd1, 1, 0, 0, c);
    c = '0; c.a = 2'd2; c.b = 2'd2;
    push(4'd2, 0, 0, 0, c);
    if (op == ADD) begin
      c = '0; c.op = 2'd2;            push(4'd3, 0, 0, 0, c);
      c = '0; c.rf_we = 1;            push(4'd8, 0, 1, 0, c);
    end else if (op == ADDI) begin
      c = '0; c.b = 2'd2; c.op = 2'd2; push(4'd4, 0, 0, 0, c);
      c = '0; c.rf_we = 1;            push(4'd8, 0, 1, 0, c);
    end else if (op == LW) begin
      c = '0; c.b = 2'd2;             push(4'd5, 0, 0, 0, c);
      c = '0; c.mem_req = 1; c.addr_sel = 1; push(4'd6, 1, 0, 0, c);
      c = '0; c.rf_we = 1; c.wb_sel = 1;     push(4'd9, 0, 1, 0, c);
    end else if (op == SW) begin
      c = '0; c.b = 2'd2;             push(4'd5, 0, 0, 0, c);
      c = '0; c.mem_req = 1; c.mem_we = 1; c.addr_sel = 1; push(4'd7, 1, 1, 0, c);
    end else if (op == BR && (f3 == 3'd0 || f3 == 3'd1)) begin
      c = '0; c.op = 2'd1; c.pc_src = 1;
      c.pc_we = (f3 == 3'd0) ? z : ~z;
      push(4'd10, 0, 1, 0, c);
    end else begin
      c = '0; c.trap = 1;             push(4'd11, 0, 0, 1, c);
    end
  endtask

  // One clock: drive mem_ready, check at negedge, advance model after posedge
  task automatic cycle();
    step_t s;
    ctl_t  e;
    logic  rdy;
    s = q[0];
    if (s.mem && s.st == wait_state && waits_left > 0) begin
      rdy = 1'b0;
      waits_left--;
    end else begin
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    mem_ready = rdy;
    @(negedge clk);
    e = s.c;
    if (s.st == 4'd1) begin
      e.ir_we = rdy;
      e.pc_we = rdy;
    end
    chk("state", 32'(state), 32'(s.st));
    chk("ctl", 32'(dut_ctl()), 32'(e));
    chk("instret", 32'(instret), 32'(model_ret % (1 << CW)));
    if (state != 4'd0) begin
      n_cyc++;
      if (n_cyc == 3) st3 = state;
      if (state == 4'd10) br_pcwe = pc_we;
    end
    @(posedge clk);
    #1;
    if (!s.sticky && (!s.mem || rdy)) begin
      void'(q.pop_front());
      if (s.retire) model_ret++;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z);
    int guard;
    guard = 0;
    opcode = op; funct3 = f3; zero = z;
    plan(op, f3, z);
    n_cyc = 0; st3 = 4'd0; br_pcwe = 1'b0;
    while (q.size() > 0 && !q[0].sticky) begin
      cycle();
      guard++;
      if (guard > 100) begin
        n_checks++; n_err++;
        $display("FAIL timeout: got no completion after %0d cycles required <=100", guard);
        q.delete();
        break;
      end
    end
    $display("instr op=%b f3=%b z=%0d cycles=%0d instret=%0d", op, f3, z, n_cyc, instret);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    model_ret = 0;
    waits_left = 0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(dut_ctl()), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(4'd0, 0, 0, 0, '0);
  endtask

  task automatic trap_hold();
    rand_ready = 1;
    repeat (20) cycle();
    chk("trap_flag", 32'(trap), 32'd1);
    chk("trap_memreq", 32'(mem_req), 32'd0);
    rand_ready = 0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{op: ADDI, f3: 3'd0, z: 1'b0, cyc: 4, st3: 4'd4,  pcwe: 1'b0};
    vecs[1] = '{op: ADD,  f3: 3'd0, z: 1'b0, cyc: 4, st3: 4'd3,  pcwe: 1'b0};
    vecs[2] = '{op: LW,   f3: 3'd2, z: 1'b0, cyc: 5, st3: 4'd5,  pcwe: 1'b0};
    vecs[3] = '{op: SW,   f3: 3'd2, z: 1'b1, cyc: 4, st3: 4'd5,  pcwe: 1'b0};
    vecs[4] = '{op: BR,   f3: 3'd0, z: 1'b1, cyc: 3, st3: 4'd10, pcwe: 1'b1};
    vecs[5] = '{op: BR,   f3: 3'd0, z: 1'b0, cyc: 3, st3: 4'd10, pcwe: 1'b0};
    vecs[6] = '{op: BR,   f3: 3'd1, z: 1'b1, cyc: 3, st3: 4'd10, pcwe: 1'b0};
    vecs[7] = '{op: BR,   f3: 3'd1, z: 1'b0, cyc: 3, st3: 4'd10, pcwe: 1'b1};

    // Directed vector table, zero wait states
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].z);
      chk($sformatf("vec%0d_cycles", i), 32'(n_cyc), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_st3", i), 32'(st3), 32'(vecs[i].st3));
      chk($sformatf("vec%0d_pcwe", i), 32'(br_pcwe), 32'(vecs[i].pcwe));
      chk($sformatf("vec%0d_instret", i), 32'(instret), 32'((i + 1) % (1 << CW)));
    end

    // LW with three wait cycles in MEM_RD
    wait_state = 4'd6; waits_left = 3;
    run_instr(LW, 3'd2, 1'b0);
    chk("lw_wait_cycles", 32'(n_cyc), 32'd8);

    // BEQ taken then BNE not taken, both with zero=1
    run_instr(BR, 3'd0, 1'b1);
    chk("beq_pcwe", 32'(br_pcwe), 32'd1);
    run_instr(BR, 3'd1, 1'b1);
    chk("bne_pcwe", 32'(br_pcwe), 32'd0);

    // Randomized instruction stream with random memory latency
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 120; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      case ($urandom_range(0, 5))
        0: op = ADDI;
        1: op = ADD;
        2: op = LW;
        3: op = SW;
        default: op = BR;
      endcase
      f3 = (op == BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr(op, f3, 1'($urandom_range(0, 1)));
    end
    rand_ready = 0;

    // Illegal opcode traps and stays trapped
    do_reset();
    run_instr(ADDI, 3'd0, 1'b0);
    run_instr(7'b1111111, 3'd0, 1'b0);
    trap_hold();
    chk("trap_instret", 32'(instret), 32'd1);

    // Illegal branch funct3 traps
    do_reset();
    run_instr(BR, 3'd4, 1'b0);
    trap_hold();
    chk("trap_br_instret", 32'(instret), 32'd0);

    // Asynchronous reset in the middle of a FETCH wait
    do_reset();
    run_instr(ADD, 3'd0, 1'b0);
    plan(ADDI, 3'd0, 1'b0);
    wait_state = 4'd1; waits_left = 5;
    cycle();
    cycle();
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_memreq", 32'(mem_req), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_instret", 32'(instret), 32'd0);
    wait_state = 4'd6;

    // Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(BR, 3'd0, 1'b0);
    chk("wrap15", 32'(instret), 32'd15);
    run_instr(BR, 3'd1, 1'b0);
    chk("wrap0", 32'(instret), 32'd0);
    run_instr(ADDI, 3'd0, 1'b0);
    chk("wrap1", 32'(instret), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running required finish");
    $fatal(1, "timeout");
  end

endmodule
